// File: rtl/fila_pkg.sv
// Shared sizing and types for the fila queue and its access controller.
package fila_pkg;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;
    localparam int LEN_W  = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OP     = 2'd1,
        SETTLE = 2'd2
    } fila_ctrl_state_t;

    typedef enum logic {
        SRC_A = 1'b0,
        SRC_B = 1'b1
    } fila_src_t;

endpackage

// File: rtl/fila.sv
// 8-entry shifting queue. The length and the dequeued item are registered,
// so both reflect an operation in the cycle after its strobe.
module fila #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int LEN_W  = 8
) (
    input  logic              clk_10KHz,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              enqueue_in,
    input  logic              dequeue_in,
    output logic [DATA_W-1:0] data_out,
    output logic [LEN_W-1:0]  len_out
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [LEN_W-1:0]  len_r;

    // Storage, length and output register; the head shifts down on dequeue.
    always_ff @(posedge clk_10KHz) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
            len_r    <= {LEN_W{1'b0}};
            data_out <= {DATA_W{1'b0}};
        end else if (enqueue_in && (len_r < LEN_W'(DEPTH))) begin
            mem_r[len_r[IDX_W-1:0]] <= data_in;
            len_r <= len_r + {{(LEN_W-1){1'b0}}, 1'b1};
        end else if (dequeue_in && (len_r != {LEN_W{1'b0}})) begin
            data_out <= mem_r[0];
            for (int i = 0; i < DEPTH - 1; i++) begin
                mem_r[i] <= mem_r[i+1];
            end
            len_r <= len_r - {{(LEN_W-1){1'b0}}, 1'b1};
        end else begin
            len_r <= len_r;
        end
    end

    assign len_out = len_r;

endmodule

// File: rtl/rr_arbiter2.sv
// Two-input round-robin picker: on a tie, the producer not granted last wins.
module rr_arbiter2
    import fila_pkg::*;
(
    input  logic      req_a,
    input  logic      req_b,
    input  fila_src_t last,
    output fila_src_t grant,
    output logic      valid
);

    // Combinational pick; grant is meaningless while valid is low.
    always_comb begin
        valid = req_a | req_b;
        if (req_a && req_b) begin
            grant = (last == SRC_A) ? SRC_B : SRC_A;
        end else if (req_b) begin
            grant = SRC_B;
        end else begin
            grant = SRC_A;
        end
    end

endmodule

// File: rtl/fila_ctrl.sv
// Access controller for fila: arbitrates two producers and one consumer onto
// the queue's single strobe pair, one operation every three cycles.
module fila_ctrl
    import fila_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int LEN_W  = 8
) (
    input  logic              clk_10KHz,
    input  logic              reset,
    input  logic              req_a,
    input  logic              req_b,
    input  logic [DATA_W-1:0] data_a,
    input  logic [DATA_W-1:0] data_b,
    output logic              ack_a,
    output logic              ack_b,
    input  logic              pop_req,
    output logic              pop_valid,
    output logic [DATA_W-1:0] pop_data,
    output logic [DATA_W-1:0] q_data,
    output logic              q_enqueue,
    output logic              q_dequeue,
    input  logic [DATA_W-1:0] q_dout,
    input  logic [LEN_W-1:0]  q_len,
    output logic              full,
    output logic              empty,
    output logic              busy
);

    fila_ctrl_state_t state_r, state_nxt;
    fila_src_t        rr_last_r, rr_last_nxt, src_r, src_nxt, pick;
    logic             deq_turn_r, deq_turn_nxt, op_deq_r, op_deq_nxt;
    logic             pick_valid, enq_ok, deq_ok, grant_enq, grant_deq;
    logic             q_enqueue_nxt, q_dequeue_nxt, ack_a_nxt, ack_b_nxt, pop_valid_nxt;
    logic [DATA_W-1:0] q_data_nxt;

    // An out-of-range length (> DEPTH) is treated as full.
    assign full     = (q_len >= LEN_W'(DEPTH));
    assign empty    = (q_len == {LEN_W{1'b0}});
    assign pop_data = q_dout;
    assign busy     = (state_r != IDLE);

    rr_arbiter2 u_arb (
        .req_a (req_a),
        .req_b (req_b),
        .last  (rr_last_r),
        .grant (pick),
        .valid (pick_valid)
    );

    // Grant decision in IDLE; deq_turn breaks an enqueue/dequeue tie.
    always_comb begin
        enq_ok    = pick_valid & ~full;
        deq_ok    = pop_req & ~empty;
        grant_deq = (state_r == IDLE) & deq_ok & (deq_turn_r | ~enq_ok);
        grant_enq = (state_r == IDLE) & enq_ok & ~grant_deq;
    end

    // State register.
    always_ff @(posedge clk_10KHz) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    // Next-state logic: IDLE -> OP -> SETTLE -> IDLE, one cycle in each busy state.
    always_comb begin
        state_nxt = state_r;
        case (state_r)
            IDLE: begin
                if (grant_enq || grant_deq) begin
                    state_nxt = OP;
                end else begin
                    state_nxt = IDLE;
                end
            end
            OP:      state_nxt = SETTLE;
            SETTLE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output and fairness next values; strobes and acks are one-cycle pulses.
    always_comb begin
        q_enqueue_nxt = 1'b0;
        q_dequeue_nxt = 1'b0;
        ack_a_nxt     = 1'b0;
        ack_b_nxt     = 1'b0;
        pop_valid_nxt = 1'b0;
        q_data_nxt    = q_data;
        deq_turn_nxt  = deq_turn_r;
        rr_last_nxt   = rr_last_r;
        src_nxt       = src_r;
        op_deq_nxt    = op_deq_r;
        case (state_r)
            IDLE: begin
                if (grant_deq) begin
                    q_dequeue_nxt = 1'b1;
                    op_deq_nxt    = 1'b1;
                end else if (grant_enq) begin
                    q_enqueue_nxt = 1'b1;
                    op_deq_nxt    = 1'b0;
                    src_nxt       = pick;
                    q_data_nxt    = (pick == SRC_A) ? data_a : data_b;
                    ack_a_nxt     = (pick == SRC_A);
                    ack_b_nxt     = (pick == SRC_B);
                end else begin
                    op_deq_nxt    = op_deq_r;
                end
            end
            OP: begin
                if (op_deq_r) begin
                    deq_turn_nxt  = 1'b0;
                    pop_valid_nxt = 1'b1;
                end else begin
                    deq_turn_nxt  = 1'b1;
                    rr_last_nxt   = src_r;
                end
            end
            SETTLE: begin
                pop_valid_nxt = 1'b0;
            end
            default: begin
                pop_valid_nxt = 1'b0;
            end
        endcase
    end

    // Registered outputs and fairness state; rr_last resets to B so A wins first.
    always_ff @(posedge clk_10KHz) begin
        if (reset) begin
            q_enqueue  <= 1'b0;
            q_dequeue  <= 1'b0;
            ack_a      <= 1'b0;
            ack_b      <= 1'b0;
            pop_valid  <= 1'b0;
            q_data     <= {DATA_W{1'b0}};
            deq_turn_r <= 1'b0;
            rr_last_r  <= SRC_B;
            src_r      <= SRC_A;
            op_deq_r   <= 1'b0;
        end else begin
            q_enqueue  <= q_enqueue_nxt;
            q_dequeue  <= q_dequeue_nxt;
            ack_a      <= ack_a_nxt;
            ack_b      <= ack_b_nxt;
            pop_valid  <= pop_valid_nxt;
            q_data     <= q_data_nxt;
            deq_turn_r <= deq_turn_nxt;
            rr_last_r  <= rr_last_nxt;
            src_r      <= src_nxt;
            op_deq_r   <= op_deq_nxt;
        end
    end

endmodule

// File: tb/tb_fila_ctrl.sv
// Scoreboard bench for fila_ctrl driving a fila queue.
`timescale 1ns/1ps
module tb_fila_ctrl;
    import fila_pkg::*;

    localparam int K_LEN = 0, K_FULL = 1, K_EMPTY = 2, K_BUSY = 3, K_ENQ = 4,
                   K_DEQ = 5, K_ACKA = 6, K_ACKB = 7, K_PV = 8;

    logic              clk_10KHz = 1'b0;
    logic              reset = 1'b1;
    logic              req_a = 1'b0, req_b = 1'b0, pop_req = 1'b0;
    logic [DATA_W-1:0] data_a = 8'h00, data_b = 8'h00;
    logic              ack_a, ack_b, pop_valid, q_enqueue, q_dequeue, full, empty, busy;
    logic [DATA_W-1:0] pop_data, q_data, q_dout;
    logic [LEN_W-1:0]  q_len;

    typedef struct { logic src; logic [7:0] data; } ack_t;
    typedef struct { int cyc; int kind; logic [7:0] val; string name; } chk_t;
    ack_t       exp_ack[$];
    logic [7:0] exp_pop[$];
    chk_t       exp_st[$];

    int cyc = 0;
    int n_vec = 0;
    int n_miss = 0;
    logic done = 1'b0;

    fila_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
        .clk_10KHz (clk_10KHz), .reset (reset),
        .req_a (req_a), .req_b (req_b), .data_a (data_a), .data_b (data_b),
        .ack_a (ack_a), .ack_b (ack_b),
        .pop_req (pop_req), .pop_valid (pop_valid), .pop_data (pop_data),
        .q_data (q_data), .q_enqueue (q_enqueue), .q_dequeue (q_dequeue),
        .q_dout (q_dout), .q_len (q_len),
        .full (full), .empty (empty), .busy (busy)
    );

    fila #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LEN_W(LEN_W)) u_q (
        .clk_10KHz (clk_10KHz), .reset (reset),
        .data_in (q_data), .enqueue_in (q_enqueue), .dequeue_in (q_dequeue),
        .data_out (q_dout), .len_out (q_len)
    );

    always #50 clk_10KHz = ~clk_10KHz;
    always @(posedge clk_10KHz) cyc <= cyc + 1;

    function automatic logic [7:0] status_val(input int kind);
        case (kind)
            K_LEN:   return q_len;
            K_FULL:  return {7'd0, full};
            K_EMPTY: return {7'd0, empty};
            K_BUSY:  return {7'd0, busy};
            K_ENQ:   return {7'd0, q_enqueue};
            K_DEQ:   return {7'd0, q_dequeue};
            K_ACKA:  return {7'd0, ack_a};
            K_ACKB:  return {7'd0, ack_b};
            K_PV:    return {7'd0, pop_valid};
            default: return 8'hEE;
        endcase
    endfunction

    // Monitor: compares every DUT event and every timed status check at the falling edge.
    initial begin
        ack_t       e;
        logic [7:0] p, act;
        chk_t       keep[$];
        forever begin
            @(negedge clk_10KHz);
            if (done) begin
                n_vec++;
                if (exp_ack.size() != 0) begin
                    n_miss++;
                    $display("FAIL ack_drain: %0d acks still expected, want 0", exp_ack.size());
                end
                n_vec++;
                if (exp_pop.size() != 0) begin
                    n_miss++;
                    $display("FAIL pop_drain: %0d pops still expected, want 0", exp_pop.size());
                end
                n_vec++;
                if (exp_st.size() != 0) begin
                    n_miss++;
                    $display("FAIL status_drain: %0d checks never reached, want 0", exp_st.size());
                end
                $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
                $finish;
            end
            if (q_enqueue || q_dequeue) begin
                n_vec++;
                if (q_enqueue && q_dequeue) begin
                    n_miss++;
                    $display("FAIL strobe_excl @%0d: enq=1 deq=1, want at most one", cyc);
                end
            end
            if (ack_a || ack_b) begin
                n_vec++;
                if (exp_ack.size() == 0) begin
                    n_miss++;
                    $display("FAIL ack_unexpected @%0d: ack_a=%0b ack_b=%0b, want no ack", cyc, ack_a, ack_b);
                end else begin
                    e = exp_ack.pop_front();
                    if ((ack_a && ack_b) || (ack_b != e.src) || (q_data !== e.data) || !q_enqueue) begin
                        n_miss++;
                        $display("FAIL ack @%0d: ack_a=%0b ack_b=%0b q_data=%02h enq=%0b, want src=%0d data=%02h enq=1",
                                 cyc, ack_a, ack_b, q_data, q_enqueue, e.src, e.data);
                    end
                end
            end
            if (pop_valid) begin
                n_vec++;
                if (exp_pop.size() == 0) begin
                    n_miss++;
                    $display("FAIL pop_unexpected @%0d: pop_data=%02h, want no pop_valid", cyc, pop_data);
                end else begin
                    p = exp_pop.pop_front();
                    if (pop_data !== p) begin
                        n_miss++;
                        $display("FAIL pop @%0d: pop_data=%02h, want %02h", cyc, pop_data, p);
                    end
                end
            end
            keep = {};
            foreach (exp_st[i]) begin
                if (exp_st[i].cyc == cyc) begin
                    act = status_val(exp_st[i].kind);
                    n_vec++;
                    if (act !== exp_st[i].val) begin
                        n_miss++;
                        $display("FAIL %s @%0d: got %0h, want %0h", exp_st[i].name, cyc, act, exp_st[i].val);
                    end
                end else begin
                    keep.push_back(exp_st[i]);
                end
            end
            exp_st = keep;
        end
    end

    task automatic tick();
        @(posedge clk_10KHz);
        #1;
    endtask

    task automatic expect_st(input int d, input int kind, input logic [7:0] v, input string nm);
        chk_t c;
        c.cyc = cyc + d; c.kind = kind; c.val = v; c.name = nm;
        exp_st.push_back(c);
    endtask

    // which: 0 = wait for an ack, 1 = wait for pop_valid
    task automatic wait_sig(input int which, input string nm);
        for (int i = 0; i < 40; i++) begin
            tick();
            if ((which == 0 && (ack_a || ack_b)) || (which == 1 && pop_valid)) return;
        end
        $display("FAIL %s: timed out after 40 cycles, want event", nm);
        $fatal(1, "event timeout");
    endtask

    task automatic do_reset();
        tick();
        reset = 1'b1; req_a = 1'b0; req_b = 1'b0; pop_req = 1'b0;
        tick();
        reset = 1'b0;
        expect_st(0, K_LEN, 8'd0, "rst_len");
        expect_st(0, K_EMPTY, 8'd1, "rst_empty");
        expect_st(0, K_FULL, 8'd0, "rst_full");
        expect_st(0, K_BUSY, 8'd0, "rst_busy");
        expect_st(0, K_ENQ, 8'd0, "rst_enq");
        expect_st(0, K_PV, 8'd0, "rst_pv");
    endtask

    task automatic enq(input logic src, input logic [7:0] d);
        ack_t e;
        e.src = src; e.data = d;
        exp_ack.push_back(e);
        if (src) begin req_b = 1'b1; data_b = d; end
        else     begin req_a = 1'b1; data_a = d; end
        wait_sig(0, "enq_wait");
        req_a = 1'b0; req_b = 1'b0;
    endtask

    task automatic pop(input logic [7:0] d);
        exp_pop.push_back(d);
        pop_req = 1'b1;
        wait_sig(1, "pop_wait");
        pop_req = 1'b0;
    endtask

    // Stimulus: directed scenarios; expectations are pushed, the monitor checks.
    initial begin
        ack_t e;
        // single enqueue latency
        do_reset();
        e.src = 1'b0; e.data = 8'h11; exp_ack.push_back(e);
        req_a = 1'b1; data_a = 8'h11;
        expect_st(1, K_ACKA, 8'd1, "t1_ack_hi");
        expect_st(1, K_ENQ, 8'd1, "t1_enq_hi");
        expect_st(1, K_LEN, 8'd0, "t1_len_op");
        expect_st(2, K_ACKA, 8'd0, "t1_ack_lo");
        expect_st(2, K_ENQ, 8'd0, "t1_enq_lo");
        expect_st(2, K_LEN, 8'd1, "t1_len_settle");
        expect_st(2, K_BUSY, 8'd1, "t1_busy_settle");
        expect_st(3, K_BUSY, 8'd0, "t1_busy_idle");
        tick();
        req_a = 1'b0;
        repeat (3) tick();

        // round-robin fill until full
        do_reset();
        for (int i = 0; i < 8; i++) begin
            e.src = i[0]; e.data = i[0] ? 8'hB0 : 8'hA0;
            exp_ack.push_back(e);
        end
        req_a = 1'b1; req_b = 1'b1; data_a = 8'hA0; data_b = 8'hB0;
        repeat (30) tick();
        expect_st(0, K_LEN, 8'd8, "t2_len_full");
        expect_st(0, K_FULL, 8'd1, "t2_full");
        expect_st(0, K_BUSY, 8'd0, "t2_blocked");
        repeat (6) tick();
        req_a = 1'b0; req_b = 1'b0;

        // fill 01..08 then drain in order
        do_reset();
        for (int i = 1; i <= 8; i++) enq(1'b0, 8'(i));
        for (int i = 1; i <= 8; i++) exp_pop.push_back(8'(i));
        pop_req = 1'b1;
        repeat (30) tick();
        pop_req = 1'b0;
        expect_st(0, K_EMPTY, 8'd1, "t3_empty");
        expect_st(0, K_LEN, 8'd0, "t3_len");
        expect_st(0, K_PV, 8'd0, "t3_pv_lo");

        // enqueue/dequeue alternation at q_len=4, last op a dequeue
        for (int i = 0; i < 5; i++) enq(1'b0, 8'h21 + 8'(i));
        pop(8'h21);
        tick();
        for (int i = 0; i < 4; i++) begin
            e.src = 1'b0; e.data = 8'h30; exp_ack.push_back(e);
            exp_pop.push_back(8'h22 + 8'(i));
        end
        req_a = 1'b1; data_a = 8'h30; pop_req = 1'b1;
        expect_st(1, K_ENQ, 8'd1, "t4_op1_enq");
        expect_st(4, K_DEQ, 8'd1, "t4_op2_deq");
        expect_st(7, K_ENQ, 8'd1, "t4_op3_enq");
        expect_st(10, K_DEQ, 8'd1, "t4_op4_deq");
        repeat (24) tick();
        req_a = 1'b0; pop_req = 1'b0;
        expect_st(0, K_LEN, 8'd4, "t4_len");

        // empty queue: consumer waits, then a B enqueue is returned
        do_reset();
        pop_req = 1'b1;
        for (int d = 1; d <= 5; d++) begin
            expect_st(d, K_BUSY, 8'd0, "t5_idle");
            expect_st(d, K_DEQ, 8'd0, "t5_no_deq");
        end
        repeat (6) tick();
        e.src = 1'b1; e.data = 8'h5C; exp_ack.push_back(e);
        exp_pop.push_back(8'h5C);
        req_b = 1'b1; data_b = 8'h5C;
        wait_sig(0, "t5_ack");
        req_b = 1'b0;
        wait_sig(1, "t5_pop");
        pop_req = 1'b0;
        tick();
        expect_st(0, K_EMPTY, 8'd1, "t5_empty");

        // reset during the OP cycle of an enqueue, then an A/B tie
        do_reset();
        e.src = 1'b0; e.data = 8'h66; exp_ack.push_back(e);
        req_a = 1'b1; data_a = 8'h66;
        expect_st(1, K_ACKA, 8'd1, "t6_ack_op");
        tick();
        reset = 1'b1; req_a = 1'b0;
        tick();
        reset = 1'b0;
        expect_st(0, K_ACKA, 8'd0, "t6_ack_cleared");
        expect_st(0, K_ENQ, 8'd0, "t6_enq_cleared");
        expect_st(0, K_BUSY, 8'd0, "t6_idle");
        expect_st(0, K_LEN, 8'd0, "t6_len");
        expect_st(0, K_PV, 8'd0, "t6_pv");
        e.src = 1'b0; e.data = 8'hA1; exp_ack.push_back(e);
        e.src = 1'b1; e.data = 8'hB1; exp_ack.push_back(e);
        req_a = 1'b1; req_b = 1'b1; data_a = 8'hA1; data_b = 8'hB1;
        expect_st(1, K_ACKA, 8'd1, "t6_a_wins_tie");
        repeat (5) tick();
        req_a = 1'b0; req_b = 1'b0;
        repeat (4) tick();
        expect_st(0, K_LEN, 8'd2, "t6_len");

        repeat (3) tick();
        done = 1'b1;
        repeat (5) tick();
        $display("FAIL summary: monitor did not finish, want summary");
        $fatal(1, "no finish");
    end

endmodule
